i2c_req_arbiter: RTL and testbench
==================================

Name: i2c_req_arbiter

Overview:
- Shares one i2c_master_ctrl_ir instance between NUM_REQ independent requesters, e.g. the LUT init sequencer, the Ethernet set_* path and a periodic sensor readback poller.
- Arbitrates round-robin, launches one transaction at a time and holds the command fields stable for the whole transfer.
- Returns rx data and error/timeout status to the granted requester, then enforces an inter-transaction gap.
- Sits between the requesters and the master's i2c_en/command/i2c_transfer_end interface.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
TIMEOUT_CYCLES, 24'hFF_FFFF, max clk cycles from i2c_en to i2c_transfer_end before abort
GAP_CYCLES, 16'd256, idle clk cycles enforced after each response (0 = no gap)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester request, level, held until req_ready
req_wr  in  NUM_REQ  1 = write, 0 = read
req_dev  in  7*NUM_REQ  7-bit device id, requester k at [7k+6:7k]
req_addr  in  16*NUM_REQ  register address
req_data  in  16*NUM_REQ  write data
req_dbytes  in  2*NUM_REQ  valid data bytes (1 or 2)
req_ready  out  NUM_REQ  one-hot 1-cycle accept pulse
rsp_valid  out  NUM_REQ  one-hot 1-cycle completion pulse
rsp_rdata  out  16  read data, valid with rsp_valid
rsp_err  out  1  NACK seen (err_flag) during transaction
rsp_timeout  out  1  transaction aborted by watchdog
i2c_en  out  1  1-cycle start to master
write_flag  out  1  to master
device_id  out  7  to master
i2c_reg_addr  out  16  to master
i2c_tx_data  out  16  to master
valid_d_bytes  out  2  to master
i2c_rx_data  in  16  from master
i2c_transfer_end  in  1  1-cycle done from master
err_flag  in  1  from master
busy  out  1  high in every state except IDLE
grant_id  out  3  index of current/last granted requester
timeout_cnt  out  16  saturating count of watchdog aborts

Behaviour:
- Reset (async, rst=1): state=IDLE; rr_ptr=0; all outputs 0; timeout_cnt=0. Takes effect immediately, including mid-transaction. Master-side recovery is the master's own reset's job.
- All outputs registered.
- States: IDLE, LAUNCH, WAIT_END, RESP, GAP.
- IDLE:
  - If any req_valid, winner = first set bit searching upward from rr_ptr with wrap.
  - Next cycle: latch winner's command fields into output regs, grant_id=winner, req_ready[winner]=1 for that one cycle, i2c_en=1 for that one cycle, state=LAUNCH.
  - Command outputs stay stable from LAUNCH until the next grant.
- LAUNCH: clear err latch, clear watchdog → WAIT_END.
- WAIT_END:
  - Watchdog increments every cycle.
  - err latch |= err_flag.
  - On i2c_transfer_end: capture i2c_rx_data → RESP.
  - Else if watchdog == TIMEOUT_CYCLES-1: set timeout flag, timeout_cnt +1 (saturate at 16'hFFFF) → RESP.
  - transfer_end and timeout in the same cycle: transfer_end wins, no timeout.
- RESP (1 cycle):
  - rsp_valid[grant_id]=1.
  - rsp_rdata = captured data, or 0 on timeout.
  - rsp_err = err latch.
  - rsp_timeout = flag.
  - rr_ptr = (grant_id+1) mod NUM_REQ.
  - → GAP, or → IDLE if GAP_CYCLES==0.
  - rsp_* fields hold until the next RESP; only rsp_valid pulses.
- GAP: count GAP_CYCLES cycles → IDLE. req_valid is ignored (not lost) during GAP.
- Latency: req_valid sampled in IDLE at cycle t → req_ready and i2c_en at t+1; rsp_valid 2 cycles after i2c_transfer_end.
- A requester deasserting req_valid before req_ready is simply not granted. After req_ready, fields may change freely.
- i2c_transfer_end outside WAIT_END is ignored.
- Only one transaction is ever outstanding. i2c_en never pulses outside the IDLE→LAUNCH edge.

Test Plan:
- Single write, requester 1: dev=7'h36, addr=16'h3008, data=16'h0082. Model ends after 500 cycles → req_ready[1] at t+1, i2c_en 1 cycle with matching fields, rsp_valid=3'b010 2 cycles after end, rsp_err=0.
- All 3 req_valid held continuously from reset → grants 0,1,2,0 in order, each separated by exactly GAP_CYCLES+ idle cycles, no overlapping i2c_en.
- Read on requester 2, model returns 16'hA5C3 with err_flag pulsed mid-transfer → rsp_rdata=16'hA5C3, rsp_err=1.
- TIMEOUT_CYCLES=1000, model never ends → rsp_valid at i2c_en+1001, rsp_timeout=1, rsp_rdata=0, timeout_cnt=1. A late i2c_transfer_end in GAP is ignored.
- transfer_end in the exact watchdog-expiry cycle → normal completion, rsp_timeout=0, timeout_cnt unchanged.
- rst pulsed during WAIT_END → all outputs 0 immediately, rr_ptr=0. After release, a pending requester 2 is granted cleanly.

Source files
------------

// File: rtl/i2c_req_arbiter.sv
// i2c_req_arbiter: round-robin arbiter sharing one I2C master between NUM_REQ requesters
//   clk, rst            : clock, asynchronous active-high reset
//   req_*               : per-requester command (valid/wr/dev/addr/data/dbytes), req_ready accept pulse
//   rsp_*               : one-hot completion pulse plus rdata/err/timeout, held until next response
//   i2c_en..valid_d_bytes, i2c_rx_data, i2c_transfer_end, err_flag : master command/status interface
//   busy, grant_id, timeout_cnt : status
module i2c_req_arbiter #(
    parameter int          NUM_REQ        = 3,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'hFF_FFFF,
    parameter logic [15:0] GAP_CYCLES     = 16'd256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ-1:0]     req_wr,
    input  logic [7*NUM_REQ-1:0]   req_dev,
    input  logic [16*NUM_REQ-1:0]  req_addr,
    input  logic [16*NUM_REQ-1:0]  req_data,
    input  logic [2*NUM_REQ-1:0]   req_dbytes,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [15:0]            rsp_rdata,
    output logic                   rsp_err,
    output logic                   rsp_timeout,
    output logic                   i2c_en,
    output logic                   write_flag,
    output logic [6:0]             device_id,
    output logic [15:0]            i2c_reg_addr,
    output logic [15:0]            i2c_tx_data,
    output logic [1:0]             valid_d_bytes,
    input  logic [15:0]            i2c_rx_data,
    input  logic                   i2c_transfer_end,
    input  logic                   err_flag,
    output logic                   busy,
    output logic [2:0]             grant_id,
    output logic [15:0]            timeout_cnt
);
    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_END, RESP, GAP} state_t;
    localparam logic [NUM_REQ-1:0] ONE = 1;
    state_t      state;
    logic [2:0]  rr_ptr, win;
    logic [23:0] wd;
    logic [15:0] gc, rx_cap;
    logic        err_l, to_l;
    logic        sel_wr;
    logic [6:0]  sel_dev;
    logic [15:0] sel_addr, sel_data;
    logic [1:0]  sel_nb;
    int          d, best;
    // Winner is the valid requester with the smallest wrapped distance from rr_ptr.
    always_comb begin
        win = '0;
        best = NUM_REQ;
        d = 0;
        sel_wr = 1'b0;
        sel_dev = '0;
        sel_addr = '0;
        sel_data = '0;
        sel_nb = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            d = (k + NUM_REQ - int'(rr_ptr)) % NUM_REQ;
            if (req_valid[k] && d < best) begin
                best = d;
                win = 3'(k);
                sel_wr = req_wr[k];
                sel_dev = req_dev[7*k +: 7];
                sel_addr = req_addr[16*k +: 16];
                sel_data = req_data[16*k +: 16];
                sel_nb = req_dbytes[2*k +: 2];
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            rr_ptr <= '0;
            wd <= '0;
            gc <= '0;
            rx_cap <= '0;
            err_l <= 1'b0;
            to_l <= 1'b0;
            req_ready <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err <= 1'b0;
            rsp_timeout <= 1'b0;
            i2c_en <= 1'b0;
            write_flag <= 1'b0;
            device_id <= '0;
            i2c_reg_addr <= '0;
            i2c_tx_data <= '0;
            valid_d_bytes <= '0;
            busy <= 1'b0;
            grant_id <= '0;
            timeout_cnt <= '0;
        end else begin
            req_ready <= '0;
            rsp_valid <= '0;
            i2c_en <= 1'b0;
            case (state)
                IDLE: if (|req_valid) begin
                    grant_id <= win;
                    req_ready <= ONE << win;
                    i2c_en <= 1'b1;
                    write_flag <= sel_wr;
                    device_id <= sel_dev;
                    i2c_reg_addr <= sel_addr;
                    i2c_tx_data <= sel_data;
                    valid_d_bytes <= sel_nb;
                    busy <= 1'b1;
                    state <= LAUNCH;
                end
                LAUNCH: begin
                    err_l <= 1'b0;
                    to_l <= 1'b0;
                    wd <= '0;
                    state <= WAIT_END;
                end
                WAIT_END: begin
                    wd <= wd + 24'd1;
                    err_l <= err_l | err_flag;
                    // wd + 1 counts the current cycle; transfer_end takes priority over expiry
                    if (i2c_transfer_end) begin
                        rx_cap <= i2c_rx_data;
                        state <= RESP;
                    end else if (wd + 24'd1 == TIMEOUT_CYCLES - 24'd1) begin
                        to_l <= 1'b1;
                        timeout_cnt <= timeout_cnt + {15'd0, timeout_cnt != 16'hFFFF};
                        state <= RESP;
                    end
                end
                RESP: begin
                    rsp_valid <= ONE << grant_id;
                    rsp_rdata <= to_l ? 16'd0 : rx_cap;
                    rsp_err <= err_l;
                    rsp_timeout <= to_l;
                    rr_ptr <= (grant_id == 3'(NUM_REQ - 1)) ? 3'd0 : grant_id + 3'd1;
                    gc <= '0;
                    busy <= GAP_CYCLES != 16'd0;
                    state <= (GAP_CYCLES == 16'd0) ? IDLE : GAP;
                end
                GAP: if (gc == GAP_CYCLES - 16'd1) begin
                    busy <= 1'b0;
                    state <= IDLE;
                end else gc <= gc + 16'd1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_req_arbiter.sv
// tb_i2c_req_arbiter: randomized scoreboard bench for i2c_req_arbiter
module tb_i2c_req_arbiter;
    localparam int N = 3;
    localparam int T = 1000;
    localparam int G = 20;
    typedef struct {
        int id; logic wr; logic [6:0] dev; logic [15:0] addr, data, rx; logic [1:0] nb;
        int dly, err_at, L, s0; logic late, first;
    } txn_t;
    logic clk = 0, rst = 1;
    logic [N-1:0] req_valid, req_wr, req_ready, rsp_valid;
    logic [7*N-1:0] req_dev;
    logic [16*N-1:0] req_addr, req_data;
    logic [2*N-1:0] req_dbytes;
    logic [15:0] rsp_rdata, i2c_reg_addr, i2c_tx_data, i2c_rx_data, timeout_cnt;
    logic rsp_err, rsp_timeout, i2c_en, write_flag, i2c_transfer_end, err_flag, busy;
    logic [6:0] device_id;
    logic [1:0] valid_d_bytes;
    logic [2:0] grant_id;
    int cyc = 0, n_chk = 0, n_bad = 0, mrr = 0, mtc = 0, last_rsp = 0;
    txn_t cmdq[$], rspq[$], mq[$], bq[$];
    i2c_req_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(24'(T)), .GAP_CYCLES(16'(G))) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_wr(req_wr), .req_dev(req_dev),
        .req_addr(req_addr), .req_data(req_data), .req_dbytes(req_dbytes), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .i2c_en(i2c_en), .write_flag(write_flag), .device_id(device_id), .i2c_reg_addr(i2c_reg_addr),
        .i2c_tx_data(i2c_tx_data), .valid_d_bytes(valid_d_bytes), .i2c_rx_data(i2c_rx_data),
        .i2c_transfer_end(i2c_transfer_end), .err_flag(err_flag), .busy(busy), .grant_id(grant_id),
        .timeout_cnt(timeout_cnt)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
        n_chk++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, a, e, cyc);
        end
    endtask
    function automatic txn_t rnd(int k);
        txn_t t;
        int r;
        t.id = k; t.wr = 1'($urandom); t.dev = 7'($urandom); t.addr = 16'($urandom);
        t.data = 16'($urandom); t.rx = 16'($urandom); t.nb = 2'($urandom_range(1, 2));
        r = int'($urandom_range(0, 15));
        t.dly = r == 0 ? -1 : r == 1 ? T - 1 : int'($urandom_range(1, 40));
        t.err_at = $urandom_range(0, 1) == 0 ? 0 : int'($urandom_range(1, t.dly < 0 ? T - 2 : t.dly));
        t.late = t.dly < 0 && $urandom_range(0, 1) == 1;
        t.L = 0; t.s0 = 0; t.first = 0;
        return t;
    endfunction
    task automatic present(int k, txn_t t);
        req_wr[k] = t.wr;
        req_dev[7*k +: 7] = t.dev;
        req_addr[16*k +: 16] = t.addr;
        req_data[16*k +: 16] = t.data;
        req_dbytes[2*k +: 2] = t.nb;
    endtask
    function automatic int idx(int k);
        for (int j = 0; j < bq.size(); j++) if (bq[j].id == k) return j;
        return -1;
    endfunction
    task automatic chk_reset();
        chk("reset_rsp", {req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy, grant_id, timeout_cnt}, 0);
        chk("reset_cmd", {i2c_en, write_flag, device_id, i2c_reg_addr, i2c_tx_data, valid_d_bytes}, 0);
    endtask
    // Called on a negedge with the arbiter idle; all queued requests are presented at once.
    task automatic run_batch();
        txn_t m[$];
        txn_t e;
        int s, w, k, j, budget;
        bit first = 1;
        s = cyc;
        budget = 1200 * bq.size() + 200;
        m = bq;
        while (m.size() > 0) begin
            w = -1;
            for (int i = 0; i < N && w < 0; i++) begin
                k = (mrr + i) % N;
                for (int q = 0; q < m.size(); q++) if (m[q].id == k) begin w = q; break; end
            end
            e = m[w]; m.delete(w);
            e.first = first; e.s0 = s; first = 0;
            cmdq.push_back(e); mq.push_back(e);
            mrr = (e.id + 1) % N;
        end
        for (int i = 0; i < N; i++) begin
            j = idx(i);
            if (j >= 0) begin present(i, bq[j]); req_valid[i] = 1'b1; end
        end
        while ((bq.size() > 0 || cmdq.size() > 0 || rspq.size() > 0) && budget > 0) begin
            @(negedge clk);
            budget--;
            for (int i = 0; i < N; i++) if (req_ready[i]) begin
                j = idx(i);
                if (j >= 0) bq.delete(j);
                j = idx(i);
                if (j >= 0) present(i, bq[j]);
                else begin req_valid[i] = 1'b0; present(i, rnd(i)); end
            end
        end
        chk("batch_done", budget > 0, 1);
        bq.delete(); cmdq.delete(); rspq.delete(); mq.delete(); req_valid = '0;
        repeat (G + 3) @(negedge clk);
        chk("idle_busy", busy, 0);
    endtask
    always @(negedge clk) begin
        txn_t ce;
        if (!rst && i2c_en) begin
            chk("en_expected", cmdq.size() > 0, 1);
            if (cmdq.size() > 0) begin
                ce = cmdq.pop_front();
                ce.L = cyc;
                chk("en_time", cyc, ce.first ? ce.s0 + 1 : last_rsp + G + 1);
                chk("ready", req_ready, 64'(1) << ce.id);
                chk("grant_id", grant_id, ce.id);
                chk("cmd", {write_flag, device_id, i2c_reg_addr, i2c_tx_data, valid_d_bytes},
                    {ce.wr, ce.dev, ce.addr, ce.data, ce.nb});
                chk("busy", busy, 1);
                rspq.push_back(ce);
            end
        end
    end
    always @(negedge clk) begin
        txn_t r;
        bit to;
        if (rst) mtc = 0;
        else if (|rsp_valid) begin
            chk("rsp_expected", rspq.size() > 0, 1);
            if (rspq.size() > 0) begin
                r = rspq.pop_front();
                to = r.dly < 0;
                if (to) mtc++;
                chk("rsp_time", cyc, r.L + (to ? T + 1 : r.dly + 2));
                chk("rsp_valid", rsp_valid, 64'(1) << r.id);
                chk("rsp_rdata", rsp_rdata, to ? 16'd0 : r.rx);
                chk("rsp_err", rsp_err, r.err_at != 0);
                chk("rsp_timeout", rsp_timeout, to);
                chk("timeout_cnt", timeout_cnt, mtc);
            end
            last_rsp = cyc;
        end
    end
    initial begin
        txn_t m;
        int lim;
        i2c_transfer_end = 0; err_flag = 0; i2c_rx_data = 0;
        forever begin
            @(negedge clk);
            if (!rst && i2c_en && mq.size() > 0) begin
                m = mq.pop_front();
                lim = m.dly < 0 ? T + 3 : m.dly;
                for (int c = 1; c <= lim + 1; c++) begin
                    @(negedge clk);
                    if (rst) break;
                    err_flag = c == m.err_at;
                    i2c_transfer_end = c == m.dly || (m.late && c == T + 3);
                    i2c_rx_data = c == m.dly ? m.rx : 16'($urandom);
                end
                err_flag = 0; i2c_transfer_end = 0;
            end
        end
    end
    initial begin
        txn_t t;
        req_valid = '0; req_wr = '0; req_dev = '0; req_addr = '0; req_data = '0; req_dbytes = '0;
        repeat (3) @(negedge clk);
        chk_reset();
        rst = 0;
        for (int i = 0; i < 4; i++) bq.push_back(rnd(i % N));
        run_batch();
        t = rnd(1); t.wr = 1; t.dev = 7'h36; t.addr = 16'h3008; t.data = 16'h0082; t.nb = 1;
        t.dly = 500; t.err_at = 0; t.late = 0;
        bq.push_back(t); run_batch();
        t = rnd(2); t.wr = 0; t.rx = 16'hA5C3; t.dly = 60; t.err_at = 30; t.late = 0;
        bq.push_back(t); run_batch();
        t = rnd(0); t.dly = -1; t.err_at = 0; t.late = 1;
        bq.push_back(t); run_batch();
        t = rnd(1); t.dly = T - 1; t.late = 0;
        bq.push_back(t); run_batch();
        for (int b = 0; b < 12; b++) begin
            for (int k = 0; k < N; k++)
                for (int n = int'($urandom_range(0, 2)); n > 0; n--) bq.push_back(rnd(k));
            if (bq.size() == 0) bq.push_back(rnd(int'($urandom_range(0, N - 1))));
            run_batch();
        end
        t = rnd(1); t.dly = 20; t.late = 0;
        bq.push_back(t); run_batch();
        t = rnd(2); t.dly = -1; t.err_at = 0; t.late = 0; t.first = 1; t.s0 = cyc;
        cmdq.push_back(t); mq.push_back(t); present(2, t); req_valid[2] = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (req_ready[2]) begin req_valid[2] = 1'b0; present(2, rnd(2)); end
        end
        rst = 1;
        #1;
        chk_reset();
        cmdq.delete(); rspq.delete(); mq.delete(); mrr = 0;
        repeat (3) @(negedge clk);
        rst = 0;
        bq.push_back(rnd(2)); bq.push_back(rnd(1));
        run_batch();
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
        $finish;
    end
endmodule
